// File: rtl/qos_vc_arbiter.sv
// qos_vc_arbiter: weighted round-robin egress scheduler for two VC FIFOs; define QOS_STRICT_PRIORITY_EN for strict VC0 priority
module qos_vc_arbiter #(
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    reset_L,
   input  logic                    vc0_empty,
   input  logic [DATA_WIDTH-1:0]   vc0_data,
   input  logic                    vc1_empty,
   input  logic [DATA_WIDTH-1:0]   vc1_data,
   input  logic                    out_full,
   input  logic [WEIGHT_WIDTH-1:0] weight0,
   input  logic [WEIGHT_WIDTH-1:0] weight1,
   output logic                    vc0_pop,
   output logic                    vc1_pop,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    valid_out,
   output logic                    active_vc
);
   typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;
   state_t state_q, state_d;
   logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic valid_q, active_q;
   logic stall;
   assign vc0_pop   = state_q == SERVE0 && !vc0_empty && !out_full;
   assign vc1_pop   = state_q == SERVE1 && !vc1_empty && !out_full;
   assign stall     = out_full && ((state_q == SERVE0 && !vc0_empty) || (state_q == SERVE1 && !vc1_empty));
   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign active_vc = active_q;
`ifdef QOS_STRICT_PRIORITY_EN
   logic unused_w;
   assign unused_w = ^{weight0, weight1, cnt_q};
   // next state: VC0 wins whenever it has data; a stalled turn holds
   always_comb begin
      cnt_d   = '0;
      state_d = stall ? state_q : !vc0_empty ? SERVE0 : !vc1_empty ? SERVE1 : IDLE;
   end
`else
   logic [WEIGHT_WIDTH-1:0] weff0, weff1;
   logic last0, last1;
   assign weff0 = (weight0 == '0) ? WEIGHT_WIDTH'(1) : weight0;
   assign weff1 = (weight1 == '0) ? WEIGHT_WIDTH'(1) : weight1;
   assign last0 = cnt_q >= weff0 - 1'b1;
   assign last1 = cnt_q >= weff1 - 1'b1;
   // next state: count pops in the turn, hand over on weight exhaustion or empty VC
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         SERVE0: begin
            if (vc0_empty) begin
               cnt_d   = '0;
               state_d = !vc1_empty ? SERVE1 : IDLE;
            end else if (vc0_pop) begin
               cnt_d   = last0 ? '0 : cnt_q + 1'b1;
               state_d = (last0 && !vc1_empty) ? SERVE1 : SERVE0;
            end
         end
         SERVE1: begin
            if (vc1_empty) begin
               cnt_d   = '0;
               state_d = !vc0_empty ? SERVE0 : IDLE;
            end else if (vc1_pop) begin
               cnt_d   = last1 ? '0 : cnt_q + 1'b1;
               state_d = (last1 && !vc0_empty) ? SERVE0 : SERVE1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = !vc0_empty ? SERVE0 : !vc1_empty ? SERVE1 : IDLE;
         end
      endcase
   end
`endif
   // state and turn counter registers
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // egress register: capture the popped word, track the serving VC
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data_q   <= '0;
         valid_q  <= 1'b0;
         active_q <= 1'b0;
      end else begin
         valid_q  <= vc0_pop | vc1_pop;
         if (vc0_pop | vc1_pop) data_q <= vc1_pop ? vc1_data : vc0_data;
         active_q <= state_q == SERVE0 ? 1'b0 : state_q == SERVE1 ? 1'b1 : active_q;
      end
   end
endmodule

// File: tb/tb_qos_vc_arbiter.sv
// tb_qos_vc_arbiter: directed-vector bench with FIFO models feeding the arbiter
module tb_qos_vc_arbiter;
   logic clk, reset_L, out_full;
   logic vc0_empty, vc1_empty, vc0_pop, vc1_pop, valid_out, active_vc;
   logic [7:0] vc0_data, vc1_data, data_out;
   logic [3:0] weight0, weight1;
   logic set0, set1;
   int set0_n, set1_n;
   int n0, n1, idx0, idx1;
   int n_tests, n_fail;
   int e0, e1;
   byte prev;
   logic [7:0] last;

   qos_vc_arbiter dut (
      .clk(clk), .reset_L(reset_L),
      .vc0_empty(vc0_empty), .vc0_data(vc0_data),
      .vc1_empty(vc1_empty), .vc1_data(vc1_data),
      .out_full(out_full), .weight0(weight0), .weight1(weight1),
      .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
      .data_out(data_out), .valid_out(valid_out), .active_vc(active_vc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign vc0_empty = n0 == 0;
   assign vc1_empty = n1 == 0;
   assign vc0_data  = idx0[7:0];
   assign vc1_data  = 8'h80 | idx1[7:0];

   // FIFO models: preload on set, otherwise drain on pop
   always @(posedge clk) begin
      if (set0) begin
         n0   <= set0_n;
         idx0 <= 0;
      end else if (vc0_pop) begin
         n0   <= n0 - 1;
         idx0 <= idx0 + 1;
      end
      if (set1) begin
         n1   <= set1_n;
         idx1 <= 0;
      end else if (vc1_pop) begin
         n1   <= n1 - 1;
         idx1 <= idx1 + 1;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic load(input int a, input int b);
      @(negedge clk);
      set0 = 1'b1; set0_n = a;
      set1 = 1'b1; set1_n = b;
      @(negedge clk);
      set0 = 1'b0; set1 = 1'b0;
      e0 = 0; e1 = 0; prev = "."; last = 8'h00;
   endtask

   // each char is one cycle: '0'/'1' pop from that VC, '.' no pop, 'x' out_full stall
   task automatic run(input string tag, input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         out_full = s[i] == "x";
         #1;
         if (prev == "0") begin
            last = e0[7:0];
            e0++;
         end else if (prev == "1") begin
            last = 8'h80 | e1[7:0];
            e1++;
         end
         check({tag, "_valid"}, valid_out, int'(prev == "0" || prev == "1"));
         check({tag, "_data"}, data_out, last);
         if (prev == "0" || prev == "1") check({tag, "_active"}, active_vc, int'(prev == "1"));
         check({tag, "_pop"}, {vc1_pop, vc0_pop}, s[i] == "0" ? 1 : s[i] == "1" ? 2 : 0);
         prev = s[i];
      end
   endtask

   task automatic restart(input int a, input int b, input logic [3:0] w0, input logic [3:0] w1);
      @(negedge clk);
      reset_L = 1'b0;
      weight0 = w0; weight1 = w1; out_full = 1'b0;
      load(a, b);
      reset_L = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      n_tests = 0; n_fail = 0;
      set0 = 1'b0; set1 = 1'b0; set0_n = 0; set1_n = 0;
      out_full = 1'b0; weight0 = 4'd3; weight1 = 4'd1;
      reset_L = 1'b1;
      #1 reset_L = 1'b0;
      #1;
      check("rst_valid", valid_out, 0);
      check("rst_data", data_out, 0);
      check("rst_active", active_vc, 0);
      check("rst_pop", {vc1_pop, vc0_pop}, 0);
`ifdef QOS_STRICT_PRIORITY_EN
      restart(0, 4, 4'd3, 4'd1);
      run("strict", "11");
      set0 = 1'b1; set0_n = 2;
      run("strict", "1");
      set0 = 1'b0;
      run("strict", "00");
`else
      restart(8, 8, 4'd3, 4'd1);
      run("wrr", "000100010");
      reset_L = 1'b0;
      #1;
      check("midrst_valid", valid_out, 0);
      check("midrst_data", data_out, 0);
      check("midrst_active", active_vc, 0);
      check("midrst_pop", {vc1_pop, vc0_pop}, 0);
      prev = "."; last = 8'h00;
      @(negedge clk);
      reset_L = 1'b1;
      #1 check("rel_pop", {vc1_pop, vc0_pop}, 0);
      run("post_rst", "0");
      restart(8, 8, 4'd0, 4'd0);
      run("zero", "010101");
      restart(8, 8, 4'd3, 4'd1);
      run("bp", "0xxxx0010");
      restart(2, 3, 4'd5, 4'd1);
      run("early", "00.111..");
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
